// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Provides the byte-enable merge used by the storage write port.
package dmem_pkg;

    localparam int unsigned LAT_MAX = 4;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned WORD_W  = 32;
    localparam logic [BE_W-1:0] BE_FULL = 4'hF;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t be_merge(word_t old_w, word_t new_w, logic [BE_W-1:0] be);
        word_t res;
        res = old_w;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO, 32-bit words, Depth entries.
// Pop on empty is ignored; push on full is prevented upstream by the credit counter.
module rsp_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  word_t           data_i,
    input  logic            pop_i,
    output word_t           data_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    word_t           mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CntW'(push_i) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents need no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side load/store responder: byte-enabled writes, pipelined in-order reads,
// credit-based request flow control and a response FIFO with backpressure.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_we,
    input  logic [WIDTH-1:0]  i_addr,
    input  logic [WORD_W-1:0] i_data,
    input  logic [BE_W-1:0]   i_be,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [WORD_W-1:0] o_rsp_data
);

    localparam int unsigned CntW = $clog2(QDEPTH + 1);

    word_t           mem_q [2**WIDTH];
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] fifo_count;
    logic            accept, wr_en, rd_en, pop;
    logic            push_valid, fifo_empty;
    word_t           rd_word, push_data, fifo_head;

    // Ready comes from the registered credit count only, so a pop frees a slot next cycle.
    assign o_req_ready = (cnt_q < CntW'(QDEPTH));
    assign accept      = i_req_valid & o_req_ready;
    assign wr_en       = accept & i_we;
    assign rd_en       = accept & ~i_we;
    assign rd_word     = mem_q[i_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[i_addr] <= be_merge(mem_q[i_addr], i_data, i_be);
        end
    end

    if (LATENCY == 1) begin : g_direct
        assign push_valid = rd_en;
        assign push_data  = rd_word;
    end else begin : g_pipe
        localparam int unsigned Stages = LATENCY - 1;
        logic [Stages-1:0] valid_q;
        word_t             data_q [Stages];

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                for (int s = 0; s < Stages; s++) begin
                    data_q[s] <= '0;
                end
            end else begin
                valid_q[0] <= rd_en;
                data_q[0]  <= rd_word;
                for (int s = 1; s < Stages; s++) begin
                    valid_q[s] <= valid_q[s-1];
                    data_q[s]  <= data_q[s-1];
                end
            end
        end

        assign push_valid = valid_q[Stages-1];
        assign push_data  = data_q[Stages-1];
    end

    rsp_fifo #(
        .Depth(QDEPTH)
    ) u_rsp_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (push_valid),
        .data_i (push_data),
        .pop_i  (pop),
        .data_o (fifo_head),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign o_rsp_valid = ~fifo_empty;
    assign pop         = o_rsp_valid & i_rsp_ready;
    assign o_rsp_data  = o_rsp_valid ? fifo_head : '0;

    always_comb begin
        cnt_d = cnt_q + CntW'(rd_en) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Queued responses are a subset of outstanding credits.
    assert property (@(posedge clk) disable iff (rst) fifo_count <= cnt_q);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven request vectors, a response
// scoreboard, and hand sequences for latency, backpressure, RAW and reset corners.
module tb_dmem_responder;

    localparam int unsigned WIDTH   = 12;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned QDEPTH  = 4;

    logic             clk;
    logic             rst;
    logic             i_req_valid;
    logic             o_req_ready;
    logic             i_we;
    logic [WIDTH-1:0] i_addr;
    logic [31:0]      i_data;
    logic [3:0]       i_be;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [31:0]      o_rsp_data;

    dmem_responder #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_be       (i_be),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_data (o_rsp_data)
    );

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_rsp   = 0;
    int          cyc     = 0;
    logic [31:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_rsp_valid && i_rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL stale_rsp: got response 0x%08h expected none", o_rsp_data);
            end else begin
                check("rsp_data", o_rsp_data, sb.pop_front());
            end
        end
    end

    task automatic do_req(input bit we, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int acc_cyc);
        bit ok;
        ok          = 1'b0;
        acc_cyc     = -1;
        i_req_valid = 1'b1;
        i_we        = we;
        i_addr      = a;
        i_data      = d;
        i_be        = be;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_req_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                ok      = 1'b1;
                break;
            end
        end
        i_req_valid = 1'b0;
        if (!ok) check("req_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vec_t vecs [15];
        int   acc;
        int   first;
        int   n0;
        int   nacc;
        bit   r;

        vecs[0]  = '{1'b0, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 32'h0};
        vecs[2]  = '{1'b1, 12'h020, 32'h0000AA00, 4'h2, 32'h0};
        vecs[3]  = '{1'b0, 12'h020, 32'h0,        4'hF, 32'h1122AA44};
        vecs[4]  = '{1'b1, 12'h030, 32'hCAFEF00D, 4'hF, 32'h0};
        vecs[5]  = '{1'b0, 12'h030, 32'h0,        4'hF, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 12'hFFF, 32'hA5A5A5A5, 4'hF, 32'h0};
        vecs[7]  = '{1'b1, 12'h000, 32'h5A5A5A5A, 4'hF, 32'h0};
        vecs[8]  = '{1'b0, 12'hFFF, 32'h0,        4'hF, 32'hA5A5A5A5};
        vecs[9]  = '{1'b0, 12'h000, 32'h0,        4'hF, 32'h5A5A5A5A};
        vecs[10] = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 12'h020, 32'h0,        4'hF, 32'h1122AA44};
        vecs[12] = '{1'b1, 12'h030, 32'h00770000, 4'h4, 32'h0};
        vecs[13] = '{1'b0, 12'h030, 32'h0,        4'hF, 32'hCA77F00D};
        vecs[14] = '{1'b0, 12'hFFF, 32'h0,        4'hF, 32'hA5A5A5A5};

        rst         = 1'b1;
        i_req_valid = 1'b0;
        i_we        = 1'b0;
        i_addr      = '0;
        i_data      = '0;
        i_be        = '0;
        i_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rsp_data", o_rsp_data, 32'h0);
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single write then read: latency and exactly one response.
        do_req(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, acc);
        do_req(1'b0, 12'h010, 32'h0, 4'hF, acc);
        sb.push_back(32'hDEADBEEF);
        n0    = n_rsp;
        first = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_rsp_valid && first < 0) first = cyc;
        end
        check("t1_latency_cycle", 32'(first), 32'(acc + int'(LATENCY) - 1));
        check("t1_one_response", 32'(n_rsp - n0), 32'd1);
        @(posedge clk);
        #1;

        // Table: byte enables, RAW back-to-back, wrap addresses, no-op write.
        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].be, acc);
            if (!vecs[i].we) sb.push_back(vecs[i].exp);
        end
        drain();

        // Credit exhaustion under backpressure.
        for (int k = 0; k < 4; k++) begin
            do_req(1'b1, 12'(12'h040 + k), 32'(32'h40000000 + k), 4'hF, acc);
        end
        i_rsp_ready = 1'b0;
        i_we        = 1'b0;
        i_be        = 4'hF;
        i_addr      = 12'h040;
        i_req_valid = 1'b1;
        nacc        = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            r = o_req_ready;
            @(posedge clk);
            #1;
            if (r) begin
                sb.push_back(32'(32'h40000000 + (nacc % 4)));
                nacc++;
                i_addr = 12'(12'h040 + (nacc % 4));
            end
        end
        check("t3_accepted", 32'(nacc), 32'(QDEPTH));
        // A write must also be refused while credits are exhausted.
        i_we   = 1'b1;
        i_addr = 12'h040;
        i_data = 32'hBAD0BAD0;
        repeat (2) @(posedge clk);
        #1 i_req_valid = 1'b0;
        @(negedge clk);
        check("t3_ready_low", 32'(o_req_ready), 32'd0);
        check("t3_rsp_valid_held", 32'(o_rsp_valid), 32'd1);
        check("t3_head_data", o_rsp_data, 32'h40000000);
        @(negedge clk);
        check("t3_head_stable", o_rsp_data, 32'h40000000);
        @(posedge clk);
        #1 i_rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_pop_cycle", 32'(o_req_ready), 32'd0);
        @(negedge clk);
        check("t3_ready_after_pop", 32'(o_req_ready), 32'd1);
        drain();
        do_req(1'b0, 12'h040, 32'h0, 4'hF, acc);
        sb.push_back(32'h40000000);
        drain();

        // Reset with reads in flight.
        i_rsp_ready = 1'b0;
        do_req(1'b0, 12'h010, 32'h0, 4'hF, acc);
        do_req(1'b0, 12'h020, 32'h0, 4'hF, acc);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("t5_rsp_data", o_rsp_data, 32'h0);
        check("t5_req_ready", 32'(o_req_ready), 32'd1);
        i_rsp_ready = 1'b1;
        n0 = n_rsp;
        repeat (10) @(posedge clk);
        check("t5_no_stale", 32'(n_rsp - n0), 32'd0);
        #1;
        do_req(1'b0, 12'h010, 32'h0, 4'hF, acc);
        sb.push_back(32'hDEADBEEF);
        do_req(1'b0, 12'h000, 32'h0, 4'hF, acc);
        sb.push_back(32'h5A5A5A5A);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
